// File: rtl/store_stage_pkg.sv
// Shared pipeline-bus types for the store stage: op encoding, FSM states,
// physical address type and the payload bundles moved between stages.
package store_stage_pkg;

    // Physical memory address as carried on the pipeline and memory buses
    typedef logic [20:0] phys_memory_address_t;

    // Operation presented by the execute stage
    typedef enum logic [1:0] {
        OP_NOP          = 2'd0,
        OP_STORE        = 2'd1,
        OP_BRANCH       = 2'd2,
        OP_STORE_BRANCH = 2'd3
    } exec_op_t;

    // Store-stage sequencing states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_REQ  = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_REDIRECT = 2'd3
    } store_state_t;

    // Operation bundle as handed over from execute
    typedef struct packed {
        exec_op_t             op;
        phys_memory_address_t addr;
        logic [63:0]          data;
        logic [63:0]          target_pc;
    } exec_bundle_t;

    // Write request as presented to the memory bus
    typedef struct packed {
        phys_memory_address_t addr;
        logic [63:0]          data;
        logic [7:0]           core;
    } mem_write_req_t;

    // Stores are doubleword-granular; low address bits must be zero
    localparam int unsigned STORE_ALIGN_BITS = 3;

    function automatic logic is_misaligned(input phys_memory_address_t addr);
        return addr[STORE_ALIGN_BITS-1:0] != '0;
    endfunction

    function automatic logic op_redirects(input exec_op_t op);
        return (op == OP_BRANCH) || (op == OP_STORE_BRANCH);
    endfunction

endpackage

// File: rtl/store_stage.sv
// Store stage: accepts store/branch operations from execute, issues aligned
// writes to memory, waits (bounded) for the write acknowledge, then
// optionally redirects fetch. Tracks acknowledged stores and sticky errors.
module store_stage
    import store_stage_pkg::*;
#(
    parameter int core_id     = 0,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        exec_valid,
    output logic        exec_ready,
    input  logic [1:0]  exec_op,
    input  logic [20:0] exec_addr,
    input  logic [63:0] exec_data,
    input  logic [63:0] exec_target_pc,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [20:0] mem_req_addr,
    output logic [63:0] mem_req_data,
    output logic [7:0]  mem_req_core,
    input  logic        mem_ack,

    output logic        redirect_valid,
    input  logic        redirect_ready,
    output logic [63:0] redirect_pc,

    output logic        error_misaligned,
    output logic        error_timeout,
    output logic [31:0] stores_done
);

    localparam int unsigned TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] WAIT_LAST = TW'(MEM_TIMEOUT - 1);

    store_state_t   state;
    store_state_t   state_nxt;
    store_state_t   after_store;
    exec_bundle_t   incoming;
    exec_bundle_t   op_q;
    mem_write_req_t req_view;
    logic [TW-1:0]  wait_cnt;
    logic [31:0]    done_cnt;
    logic           err_mis_q;
    logic           err_to_q;
    logic           accept;
    logic           drop_store;
    logic           ack_fire;
    logic           timeout_fire;

    // Bundle the execute-side inputs for latching and decode
    always_comb begin
        incoming.op        = exec_op_t'(exec_op);
        incoming.addr      = exec_addr;
        incoming.data      = exec_data;
        incoming.target_pc = exec_target_pc;
    end

    assign accept      = exec_valid && exec_ready;
    assign after_store = (op_q.op == OP_STORE_BRANCH) ? ST_REDIRECT : ST_IDLE;

    // Next-state decode plus single-cycle event strobes
    always_comb begin
        state_nxt    = state;
        drop_store   = 1'b0;
        ack_fire     = 1'b0;
        timeout_fire = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (incoming.op)
                        OP_NOP:    state_nxt = ST_IDLE;
                        OP_BRANCH: state_nxt = ST_REDIRECT;
                        default: begin
                            // Misaligned stores are dropped; a store-branch still redirects
                            if (is_misaligned(incoming.addr)) begin
                                drop_store = 1'b1;
                                state_nxt  = op_redirects(incoming.op) ? ST_REDIRECT : ST_IDLE;
                            end else begin
                                state_nxt  = ST_MEM_REQ;
                            end
                        end
                    endcase
                end
            end
            ST_MEM_REQ: begin
                if (mem_req_ready) begin
                    state_nxt = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                // An ack in the final allowed cycle wins over the timeout
                if (mem_ack) begin
                    ack_fire  = 1'b1;
                    state_nxt = after_store;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout_fire = 1'b1;
                    state_nxt    = after_store;
                end
            end
            ST_REDIRECT: begin
                if (redirect_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, latched payload, wait counter, store count and sticky errors
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            wait_cnt  <= '0;
            done_cnt  <= '0;
            err_mis_q <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q <= incoming;
            end
            if ((state == ST_MEM_WAIT) && (state_nxt == ST_MEM_WAIT)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (ack_fire) begin
                done_cnt <= done_cnt + 32'd1;
            end
            if (drop_store) begin
                err_mis_q <= 1'b1;
            end
            if (timeout_fire) begin
                err_to_q <= 1'b1;
            end
        end
    end

    // Memory request view; core id is only driven while a request is offered
    always_comb begin
        req_view.addr = op_q.addr;
        req_view.data = op_q.data;
        req_view.core = (state == ST_MEM_REQ) ? 8'(core_id) : '0;
    end

    // Output decode from state and latched payload
    always_comb begin
        exec_ready       = (state == ST_IDLE);
        mem_req_valid    = (state == ST_MEM_REQ);
        mem_req_addr     = req_view.addr;
        mem_req_data     = req_view.data;
        mem_req_core     = req_view.core;
        redirect_valid   = (state == ST_REDIRECT);
        redirect_pc      = op_q.target_pc;
        error_misaligned = err_mis_q;
        error_timeout    = err_to_q;
        stores_done      = done_cnt;
    end

endmodule

// File: tb/tb_store_stage.sv
// Testbench for store_stage: directed scenarios followed by random operations,
// each checked against a transaction-level model of the stage's behaviour.
module tb_store_stage;

    localparam int TO   = 4;
    localparam int CORE = 90;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        exec_valid = 1'b0;
    logic        exec_ready;
    logic [1:0]  exec_op = '0;
    logic [20:0] exec_addr = '0;
    logic [63:0] exec_data = '0;
    logic [63:0] exec_target_pc = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [20:0] mem_req_addr;
    logic [63:0] mem_req_data;
    logic [7:0]  mem_req_core;
    logic        mem_ack = 1'b0;
    logic        redirect_valid;
    logic        redirect_ready = 1'b0;
    logic [63:0] redirect_pc;
    logic        error_misaligned;
    logic        error_timeout;
    logic [31:0] stores_done;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Model state: acknowledged stores and sticky error flags
    logic [31:0] m_done = '0;
    logic        m_mis = 1'b0;
    logic        m_to = 1'b0;

    always #5 clk = ~clk;

    store_stage #(.core_id(CORE), .MEM_TIMEOUT(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .exec_valid       (exec_valid),
        .exec_ready       (exec_ready),
        .exec_op          (exec_op),
        .exec_addr        (exec_addr),
        .exec_data        (exec_data),
        .exec_target_pc   (exec_target_pc),
        .mem_req_valid    (mem_req_valid),
        .mem_req_ready    (mem_req_ready),
        .mem_req_addr     (mem_req_addr),
        .mem_req_data     (mem_req_data),
        .mem_req_core     (mem_req_core),
        .mem_ack          (mem_ack),
        .redirect_valid   (redirect_valid),
        .redirect_ready   (redirect_ready),
        .redirect_pc      (redirect_pc),
        .error_misaligned (error_misaligned),
        .error_timeout    (error_timeout),
        .stores_done      (stores_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"},  exec_ready, 1);
        chk({tag, "_valids"}, {mem_req_valid, redirect_valid}, 0);
        chk({tag, "_raddr"},  mem_req_addr, 0);
        chk({tag, "_rdata"},  mem_req_data, 0);
        chk({tag, "_rcore"},  mem_req_core, 0);
        chk({tag, "_rpc"},    redirect_pc, 0);
        chk({tag, "_errs"},   {error_misaligned, error_timeout}, 0);
        chk({tag, "_done"},   stores_done, 0);
    endtask

    // One operation end to end. rdy_lat: cycles mem_req_ready is held low;
    // ack_lat: silent wait cycles before ack (>= TO means no ack at all);
    // redir_lat: cycles redirect_ready is held low.
    task automatic run_op(input logic [1:0] op, input logic [20:0] addr,
                          input logic [63:0] data, input logic [63:0] tgt,
                          input int rdy_lat, input int ack_lat, input int redir_lat);
        bit st, br, mis;
        int unsigned guard;
        st  = (op == 2'd1 || op == 2'd3) && (addr[2:0] == 3'd0);
        mis = (op == 2'd1 || op == 2'd3) && (addr[2:0] != 3'd0);
        br  = (op == 2'd2 || op == 2'd3);
        guard = 0;
        while (exec_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_ready", exec_ready, 1);
        exec_valid = 1'b1;
        exec_op = op;
        exec_addr = addr;
        exec_data = data;
        exec_target_pc = tgt;
        mem_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        exec_valid = 1'b0;
        mem_ack = 1'b0;
        exec_op = 2'($urandom);
        exec_addr = 21'($urandom);
        exec_data = {$urandom, $urandom};
        exec_target_pc = {$urandom, $urandom};
        if (mis) m_mis = 1'b1;
        if (st) begin
            for (int i = 0; i <= rdy_lat; i++) begin
                chk("req_valid", mem_req_valid, 1);
                chk("req_addr", mem_req_addr, addr);
                chk("req_data", mem_req_data, data);
                chk("req_core", mem_req_core, CORE);
                chk("req_busy", {exec_ready, redirect_valid}, 0);
                mem_req_ready = (i == rdy_lat);
                mem_ack = 1'($urandom_range(0, 1));
                @(negedge clk);
                mem_req_ready = 1'b0;
                mem_ack = 1'b0;
            end
            for (int w = 0; w < TO; w++) begin
                chk("wait_busy", {mem_req_valid, exec_ready, redirect_valid}, 0);
                mem_ack = (w == ack_lat);
                @(negedge clk);
                mem_ack = 1'b0;
                if (w == ack_lat) break;
            end
            if (ack_lat < TO) m_done++;
            else m_to = 1'b1;
        end else begin
            chk("no_req", mem_req_valid, 0);
        end
        if (br) begin
            for (int i = 0; i <= redir_lat; i++) begin
                chk("redir_valid", redirect_valid, 1);
                chk("redir_pc", redirect_pc, tgt);
                chk("redir_busy", {exec_ready, mem_req_valid}, 0);
                redirect_ready = (i == redir_lat);
                mem_ack = 1'($urandom_range(0, 1));
                @(negedge clk);
                redirect_ready = 1'b0;
                mem_ack = 1'b0;
            end
        end
        chk("back_idle", {exec_ready, mem_req_valid, redirect_valid}, 3'b100);
        chk("stores_done", stores_done, m_done);
        chk("err_mis", error_misaligned, m_mis);
        chk("err_to", error_timeout, m_to);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  r_op;
        logic [20:0] r_addr;
        // Reset state, observed before any clock edge
        #1;
        chk_reset_outputs("reset_init");
        @(negedge clk);
        reset = 1'b0;

        // Write never acknowledged: timeout after TO wait cycles, no count
        run_op(2'd1, 21'h000040, 64'h1111_2222_3333_4444, 64'h0, 0, TO, 0);
        // Plain store, ack on the third wait cycle
        run_op(2'd1, 21'h000100, 64'h0000_0000_DEAD_BEEF, 64'h0, 0, 2, 0);
        // Branch with fetch back-pressured for 5 cycles
        run_op(2'd2, 21'h000000, 64'h0, 64'h4000, 0, 0, 5);
        // Store then redirect; write must complete first
        run_op(2'd3, 21'h000008, 64'hCAFE_F00D_0123_4567, 64'h2000, 1, 1, 0);
        // Misaligned store dropped, next op accepted
        run_op(2'd1, 21'h000003, 64'h5555, 64'h0, 0, 0, 0);
        run_op(2'd0, 21'h000000, 64'h0, 64'h0, 0, 0, 0);
        // Misaligned store-branch still redirects
        run_op(2'd3, 21'h000005, 64'h7777, 64'h3000, 0, 0, 1);

        // Reset during MEM_WAIT, then a stray ack
        exec_valid = 1'b1;
        exec_op = 2'd1;
        exec_addr = 21'h000080;
        exec_data = 64'h9999;
        @(negedge clk);
        exec_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk_reset_outputs("reset_mid");
        @(negedge clk);
        reset = 1'b0;
        m_done = '0;
        m_mis = 1'b0;
        m_to = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("stray_ack_done", stores_done, 0);
        chk("stray_ack_idle", {exec_ready, mem_req_valid, redirect_valid}, 3'b100);
        repeat (TO + 1) @(negedge clk);
        chk("post_reset_no_timeout", {error_timeout, error_misaligned}, 0);
        chk("post_reset_idle", exec_ready, 1);

        // Randomised operations
        for (int n = 0; n < 40; n++) begin
            r_op = 2'($urandom);
            r_addr = 21'($urandom);
            if ($urandom_range(0, 3) != 0) r_addr[2:0] = 3'd0;
            run_op(r_op, r_addr, {$urandom, $urandom}, {$urandom, $urandom},
                   $urandom_range(0, 2), $urandom_range(0, TO), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
